// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with double-buffered display data.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_scan_ctrl #(
    parameter int DIGITS   = 6,
    parameter int SCAN_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  hex_mode,
    output logic [7:0]            seg_data,
    output logic [DIGITS-1:0]     digit_sel,
    output logic                  frame_done,
    output logic                  upd_ack
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
    localparam logic [PW-1:0] LAST_PC  = PW'(SCAN_DIV - 1);

    logic [PW-1:0]         r_pc;
    logic [IW-1:0]         r_idx;
    logic                  r_pend_valid;
    logic [4*DIGITS-1:0]   r_pend_codes;
    logic [DIGITS-1:0]     r_pend_dp;
    logic [DIGITS-1:0]     r_pend_blank;
    logic                  r_pend_hex;
    logic [4*DIGITS-1:0]   r_act_codes;
    logic [DIGITS-1:0]     r_act_dp;
    logic [DIGITS-1:0]     r_act_blank;
    logic                  r_act_hex;
    logic [7:0]            r_seg;
    logic [DIGITS-1:0]     r_sel;
    logic                  r_frame;
    logic                  r_ack;

    logic                  w_tick;
    logic                  w_wrap;
    logic                  w_commit;
    logic [IW-1:0]         w_idx_next;
    logic [4*DIGITS-1:0]   w_codes_n;
    logic [DIGITS-1:0]     w_dp_n;
    logic [DIGITS-1:0]     w_blank_n;
    logic                  w_hex_n;
    logic [3:0]            w_code_arr [DIGITS];
    logic [DIGITS-1:0]     w_supp;
    logic [3:0]            w_code_sel;
    logic [7:0]            w_seg_next;
    logic [DIGITS-1:0]     w_sel_next;

    function automatic logic [6:0] f_seg7(input logic [3:0] code, input logic hex);
        logic [6:0] seg;
        case (code)
            4'd0:  seg = 7'h3F;
            4'd1:  seg = 7'h06;
            4'd2:  seg = 7'h5B;
            4'd3:  seg = 7'h4F;
            4'd4:  seg = 7'h66;
            4'd5:  seg = 7'h6D;
            4'd6:  seg = 7'h7D;
            4'd7:  seg = 7'h07;
            4'd8:  seg = 7'h7F;
            4'd9:  seg = 7'h6F;
            4'd10: seg = hex ? 7'h77 : 7'h00;
            4'd11: seg = hex ? 7'h7C : 7'h00;
            4'd12: seg = hex ? 7'h39 : 7'h00;
            4'd13: seg = hex ? 7'h5E : 7'h00;
            4'd14: seg = hex ? 7'h79 : 7'h00;
            default: seg = hex ? 7'h71 : 7'h00;
        endcase
        return seg;
    endfunction

    assign w_tick     = (r_pc == LAST_PC);
    assign w_wrap     = w_tick && (r_idx == LAST_IDX);
    assign w_commit   = w_wrap && r_pend_valid;
    assign w_idx_next = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;

    // Outputs are decoded from the post-commit view so a new value appears on its first digit
    assign w_codes_n = w_commit ? r_pend_codes : r_act_codes;
    assign w_dp_n    = w_commit ? r_pend_dp    : r_act_dp;
    assign w_blank_n = w_commit ? r_pend_blank : r_act_blank;
    assign w_hex_n   = w_commit ? r_pend_hex   : r_act_hex;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_unpack
            assign w_code_arr[gi] = w_codes_n[4*gi +: 4];
        end
    endgenerate

`ifdef SEG_LZB_EN
    logic w_run;
    always_comb begin
        w_supp = '0;
        w_run  = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_run     = w_run && (w_code_arr[i] == 4'd0);
            w_supp[i] = w_run;
        end
    end
`else
    assign w_supp = '0;
`endif

    assign w_code_sel = w_code_arr[w_idx_next];
    assign w_sel_next = {{(DIGITS-1){1'b0}}, 1'b1} << w_idx_next;

    always_comb begin
        w_seg_next = {w_dp_n[w_idx_next], f_seg7(w_code_sel, w_hex_n)};
        if (w_supp[w_idx_next]) begin
            w_seg_next[6:0] = 7'h00;
        end
        if (w_blank_n[w_idx_next]) begin
            w_seg_next = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= '0;
            r_idx        <= LAST_IDX;
            r_pend_valid <= 1'b0;
            r_pend_codes <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '0;
            r_pend_hex   <= 1'b0;
            r_act_codes  <= '0;
            r_act_dp     <= '0;
            r_act_blank  <= '1;
            r_act_hex    <= 1'b0;
            r_seg        <= 8'h00;
            r_sel        <= '0;
            r_frame      <= 1'b0;
            r_ack        <= 1'b0;
        end else begin
            r_pc    <= w_tick ? '0 : r_pc + 1'b1;
            r_frame <= w_wrap;
            r_ack   <= w_commit;
            if (w_tick) begin
                r_idx <= w_idx_next;
                r_seg <= w_seg_next;
                r_sel <= w_sel_next;
            end
            if (w_commit) begin
                r_act_codes <= r_pend_codes;
                r_act_dp    <= r_pend_dp;
                r_act_blank <= r_pend_blank;
                r_act_hex   <= r_pend_hex;
            end
            // A load on the wrap edge refills pending after the old contents were committed
            if (load) begin
                r_pend_codes <= digits_in;
                r_pend_dp    <= dp_in;
                r_pend_blank <= blank_in;
                r_pend_hex   <= hex_mode;
                r_pend_valid <= 1'b1;
            end else if (w_commit) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    assign seg_data   = r_seg;
    assign digit_sel  = r_sel;
    assign frame_done = r_frame;
    assign upd_ack    = r_ack;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomised and directed bench for seg_scan_ctrl against a cycle-count based reference model.
// Leading-zero expectations follow SEG_LZB_EN when it is defined for the build.
module tb_seg_scan_ctrl;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 load = 1'b0;
    logic [4*DIGITS-1:0]  digits_in = '0;
    logic [DIGITS-1:0]    dp_in = '0;
    logic [DIGITS-1:0]    blank_in = '0;
    logic                 hex_mode = 1'b0;
    logic [7:0]           seg_data;
    logic [DIGITS-1:0]    digit_sel;
    logic                 frame_done;
    logic                 upd_ack;

    seg_scan_ctrl #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .dp_in(dp_in),
        .blank_in(blank_in), .hex_mode(hex_mode), .seg_data(seg_data),
        .digit_sel(digit_sel), .frame_done(frame_done), .upd_ack(upd_ack)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference state: edges since reset release plus the two data buffers
    int                   m_cnt;
    logic                 m_pv;
    logic [4*DIGITS-1:0]  m_p_codes, m_a_codes;
    logic [DIGITS-1:0]    m_p_dp, m_a_dp, m_p_blank, m_a_blank;
    logic                 m_p_hex, m_a_hex;
    logic [7:0]           m_seg;
    logic [DIGITS-1:0]    m_sel;
    logic                 m_frame, m_ack;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_decode(input int d);
        logic [3:0] code;
        logic [6:0] s;
        bit         lead;
        code = m_a_codes[4*d +: 4];
        if (m_a_blank[d]) return 8'h00;
        s = (code < 4'd10 || m_a_hex) ? seg_tab[code] : 7'h00;
        lead = (d != 0);
        for (int k = d; k < DIGITS; k++) begin
            if (m_a_codes[4*k +: 4] != 4'd0) lead = 0;
        end
`ifdef SEG_LZB_EN
        if (lead) s = 7'h00;
`endif
        return {m_a_dp[d], s};
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_pv = 0;
        m_p_codes = '0; m_p_dp = '0; m_p_blank = '0; m_p_hex = 0;
        m_a_codes = '0; m_a_dp = '0; m_a_blank = '1; m_a_hex = 0;
        m_seg = 8'h00; m_sel = '0; m_frame = 0; m_ack = 0;
    endtask

    task automatic model_edge();
        int  d;
        bit  commit;
        if (rst) begin
            model_reset();
        end else begin
            commit  = 0;
            m_cnt++;
            m_frame = 0;
            m_ack   = 0;
            if (m_cnt % SCAN_DIV == 0) begin
                d = ((m_cnt / SCAN_DIV) - 1) % DIGITS;
                if (d == 0) begin
                    m_frame = 1;
                    if (m_pv) begin
                        commit = 1;
                        m_ack = 1;
                        m_a_codes = m_p_codes; m_a_dp = m_p_dp;
                        m_a_blank = m_p_blank; m_a_hex = m_p_hex;
                    end
                end
                m_sel = DIGITS'(1) << d;
                m_seg = m_decode(d);
            end
            if (load) begin
                m_p_codes = digits_in; m_p_dp = dp_in; m_p_blank = blank_in;
                m_p_hex = hex_mode; m_pv = 1;
            end else if (commit) begin
                m_pv = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("seg_data", 32'(seg_data), 32'(m_seg));
        check("digit_sel", 32'(digit_sel), 32'(m_sel));
        check("frame_done", 32'(frame_done), 32'(m_frame));
        check("upd_ack", 32'(upd_ack), 32'(m_ack));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(input logic [15:0] codes, input logic [3:0] dp,
                           input logic [3:0] blank, input logic hex);
        digits_in = codes; dp_in = dp; blank_in = blank; hex_mode = hex; load = 1'b1;
        $display("load codes=%h dp=%b blank=%b hex=%0d t=%0t", codes, dp, blank, hex, $time);
        step();
        load = 1'b0;
    endtask

    task automatic run_to_wrap(input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (!m_frame && n < 40);
        check({tag, "_wrap_seen"}, 32'(frame_done), 32'd1);
    endtask

    // Steps until the next edge is a wrap tick
    task automatic align_before_wrap();
        int n = 0;
        while (!(((m_cnt + 1) % SCAN_DIV == 0) && ((((m_cnt + 1) / SCAN_DIV) - 1) % DIGITS == 0))
               && n < 40) begin
            step();
            n++;
        end
        check("align_bound", 32'(n < 40), 32'd1);
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        run(2);
        check("rst_seg", 32'(seg_data), 32'h0);
        check("rst_sel", 32'(digit_sel), 32'h0);
        rst = 1'b0;
        run(3);
        step();
        check("first_sel", 32'(digit_sel), 32'h1);
        check("first_frame", 32'(frame_done), 32'h1);
        check("first_seg", 32'(seg_data), 32'h0);

        run(6);
        do_load(16'h1234, 4'b0000, 4'b0000, 1'b0);
        run_to_wrap("p2");
        check("p2_seg0", 32'(seg_data), 32'h66);
        check("p2_ack", 32'(upd_ack), 32'h1);
        run(16);

        do_load(16'hABCF, 4'b0001, 4'b0000, 1'b1);
        run_to_wrap("p3a");
        check("p3_hex_d0", 32'(seg_data), 32'hF1);
        run(16);
        do_load(16'hABCF, 4'b0001, 4'b0000, 1'b0);
        run_to_wrap("p3b");
        check("p3_nohex_d0", 32'(seg_data), 32'h80);
        run(16);

        run(2);
        do_load(16'h1111, 4'b0000, 4'b0000, 1'b0);
        run(3);
        do_load(16'h2222, 4'b0000, 4'b0000, 1'b0);
        run_to_wrap("p4");
        check("p4_seg", 32'(seg_data), 32'h5B);
        run(15);
        align_before_wrap();
        do_load(16'h9876, 4'b0000, 4'b0000, 1'b0);
        check("p4_wrap_load_noack", 32'(upd_ack), 32'h0);
        run(16);
        check("p4_next_frame_ack", 32'(upd_ack), 32'h1);

        do_load(16'h0050, 4'b0000, 4'b0000, 1'b0);
        run_to_wrap("p5a");
        run(16);
        do_load(16'h0000, 4'b0000, 4'b0000, 1'b0);
        run_to_wrap("p5b");
        check("p5_zero_d0", 32'(seg_data), 32'h3F);
        run(16);

        while (m_sel != 4'b0100 && m_cnt < 100000) step();
        do_load(16'h4321, 4'b1111, 4'b0000, 1'b0);
        rst = 1'b1;
        step();
        check("p6_rst_seg", 32'(seg_data), 32'h0);
        check("p6_rst_ack", 32'(upd_ack), 32'h0);
        rst = 1'b0;
        run(24);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) rst = 1'b1;
            if ($urandom_range(0, 7) == 0) begin
                do_load(16'($urandom), 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0),
                        1'($urandom));
            end else begin
                step();
            end
            rst = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Parametrised multiplexed 7-segment display controller for the clock display path. It holds DIGITS nibble codes, scans them one digit at a time at a programmable rate, and decodes each code to an 8-bit segment pattern: 0–9, optional hex A–F, per-digit blanking and decimal point. New display data is double-buffered and committed only at a frame boundary, so a partially updated value is never shown.

## Interface
Parameters:
- DIGITS, 6: number of digits scanned; legal range 2..8.
- SCAN_DIV, 1000: clk cycles per digit slot; legal range ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous and active-high.
- load  in  1  one-cycle strobe that captures the inputs below into the pending buffer.
- digits_in  in  4*DIGITS  digit codes; bits [4i+3:4i] hold digit i, digit 0 is least significant.
- dp_in  in  DIGITS  decimal point per digit.
- blank_in  in  DIGITS  force-blank per digit.
- hex_mode  in  1  1 = codes 10–15 show A–F; 0 = codes 10–15 are blank.
- seg_data  out  8  segment pattern, active-high; bit0 = a … bit6 = g, bit7 = dp.
- digit_sel  out  DIGITS  one-hot, active-high digit enable.
- frame_done  out  1  one-cycle pulse when the scan wraps to digit 0.
- upd_ack  out  1  one-cycle pulse when pending data is committed to the active buffer.

## Operation
- Prescaler `pc` counts 0..SCAN_DIV-1. A tick occurs on the cycle where pc = SCAN_DIV-1; pc then returns to 0.
- On each tick, index `idx` advances modulo DIGITS. DIGITS-1 → 0 is the wrap.
- Pending buffer:
  - When load = 1, the block captures digits_in, dp_in, blank_in and hex_mode, and sets pend_valid.
  - A later load before commit overwrites the pending data. Only the last load is committed.
- Commit happens at the wrap tick, only if pend_valid was already 1 before that edge:
  - active ← pending; pend_valid ← 0; upd_ack = 1.
  - A load in the same cycle as the wrap tick goes to pending and is committed at the next wrap.
- Decode of the active digit:
  - Codes 0–9: 3F 06 5B 4F 66 6D 7D 07 7F 6F.
  - With hex_mode = 1, codes 10–15 give A=77, b=7C, C=39, d=5E, E=79, F=71.
  - With hex_mode = 0, codes 10–15 give 00.
  - bit7 = dp of that digit.
  - A digit with blank = 1 drives seg_data = 00, dp included. digit_sel is still driven for that digit.
- seg_data, digit_sel, frame_done and upd_ack are all registered and update on the tick edge, from the new idx and the post-commit active data.

## Timing
- Reset values:
  - pc = 0; idx = DIGITS-1; pend_valid = 0.
  - Active codes, dp and hex_mode = 0; active blank = all ones.
  - seg_data = 00; digit_sel = 0; frame_done = 0; upd_ack = 0.
- The first tick after reset is SCAN_DIV cycles after rst falls. It wraps to digit 0, so frame_done pulses on that tick.
- Digit slot length is exactly SCAN_DIV cycles. A frame is DIGITS × SCAN_DIV cycles.
- Load-to-display latency runs from the capture edge to the next wrap tick: minimum 1 cycle, maximum DIGITS × SCAN_DIV cycles.
- frame_done and upd_ack are high for exactly one cycle. They coincide when a commit occurs.
- rst mid-frame returns every register to its reset value on the next edge. Pending data is discarded and upd_ack is not issued.
- SCAN_DIV = 1 ticks every cycle, giving one digit per clk.

## Configuration
- SEG_LZB_EN defined: leading-zero blanking.
  - Scanning from digit DIGITS-1 downward, segments a–g are forced to 0 for every code-0 digit whose more-significant digits are all code 0.
  - Digit 0 is never suppressed.
  - dp is unaffected by suppression.
  - blank_in still blanks the whole digit.
- SEG_LZB_EN undefined: zeros are always displayed as 3F.

## Test plan
Bench parameters DIGITS = 4, SCAN_DIV = 4 unless noted.
1. Release rst → all outputs 0 for 3 cycles; 4th cycle: digit_sel = 0001, frame_done = 1, seg_data = 00 (reset blank).
2. Mid-frame load of 0x1234, dp = 0000, blank = 0000, hex_mode = 0 → no change until wrap; at wrap upd_ack = frame_done = 1. Then seg_data = 66, 4F, 5B, 06 for digit_sel = 0001, 0010, 0100, 1000 respectively, each held 4 cycles.
3. Load 0xAbCF with hex_mode = 1, dp = 0001 → digit0 = F1, digit1 = 39, digit2 = 7C, digit3 = 77. Repeat with hex_mode = 0 → digit0 = 80, other digits 00.
4. Two loads in one frame (0x1111 then 0x2222) → one upd_ack only, all digits 5B. Then a load asserted exactly on the wrap cycle → committed one frame later.
5. Load 0x0050: with SEG_LZB_EN, digits 3..0 = 00, 00, 6D, 3F; without the macro, 3F, 3F, 6D, 3F. Load 0x0000 with SEG_LZB_EN → digit0 = 3F, others 00.
6. Assert rst during digit 2 with a pending load → next cycle all outputs 0, no upd_ack; the first wrap after release shows blank digits.
